// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the traffic phase controller:
//               the 3-bit FSM state encoding, lamp index constants and a
//               helper that maps (state, served) to a per-approach lamp code.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam int c_state_w = 3;

    typedef enum logic [c_state_w-1:0] {
        GREEN_BASE = 3'd0,
        GREEN_EXT  = 3'd1,
        YELLOW     = 3'd2,
        ALL_RED    = 3'd3,
        WALK       = 3'd4
    } state_t;

    // Bit positions inside a 3-bit per-approach lamp code
    localparam int c_lamp_red = 0;
    localparam int c_lamp_yel = 1;
    localparam int c_lamp_grn = 2;

    // Exactly one lamp bit is set: green/yellow only for the served approach
    function automatic logic [2:0] lamp_code(input state_t st, input logic served);
        logic [2:0] l;
        l = '0;
        if (served && (st == GREEN_BASE || st == GREEN_EXT)) begin
            l[c_lamp_grn] = 1'b1;
        end else if (served && st == YELLOW) begin
            l[c_lamp_yel] = 1'b1;
        end else begin
            l[c_lamp_red] = 1'b1;
        end
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Down-counter for one traffic interval. Loaded with
//               (duration-1), decremented on tick, and reports expiry when
//               the count is zero on a tick cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer #(
    parameter int                 TIMER_W   = 8,
    parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               expired
);

    logic [TIMER_W-1:0] r_count;

    // Load wins over counting; the count parks at zero until the next load
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign expired = (r_count == '0) && tick;

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : Actuated traffic signal controller serving NUM_PHASES
//               conflicting approaches in rotation with one green extension,
//               yellow, all-red clearance and an optional pedestrian walk.
//               Optional feature macro: TLC_SKIP_IDLE_EN (phase advance skips
//               approaches with no vehicle present; approach 0 never skipped).
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int TIMER_W    = 8,
    parameter int BASE_TICKS = 10,
    parameter int EXT_TICKS  = 5,
    parameter int YEL_TICKS  = 3,
    parameter int CLR_TICKS  = 1,
    parameter int WALK_TICKS = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_PHASES-1:0]         sensor,
    input  logic                          walk_req,
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         yel,
    output logic [NUM_PHASES-1:0]         grn,
    output logic                          walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [c_state_w-1:0]          state,
    output logic                          step
);

    localparam int c_ph_w = $clog2(NUM_PHASES);

    localparam logic [TIMER_W-1:0] c_base_ld = TIMER_W'(BASE_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_ext_ld  = TIMER_W'(EXT_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_yel_ld  = TIMER_W'(YEL_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_clr_ld  = TIMER_W'(CLR_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_walk_ld = TIMER_W'(WALK_TICKS - 1);

    localparam logic [NUM_PHASES-1:0] c_rst_grn = NUM_PHASES'(1);

    state_t                  r_state;
    logic [c_ph_w-1:0]       r_phase;
    logic                    r_walk_pending;
    logic [NUM_PHASES-1:0]   r_red;
    logic [NUM_PHASES-1:0]   r_yel;
    logic [NUM_PHASES-1:0]   r_grn;
    logic                    r_walk;
    logic                    r_step;

    logic                    w_expired;
    state_t                  w_next_state;
    logic [c_ph_w-1:0]       w_next_phase;
    logic [c_ph_w-1:0]       w_adv_phase;
    state_t                  w_nx_state;
    logic [c_ph_w-1:0]       w_nx_phase;
    logic [TIMER_W-1:0]      w_load_val;
    logic [2:0]              w_lamp;
    logic [NUM_PHASES-1:0]   w_red_d;
    logic [NUM_PHASES-1:0]   w_yel_d;
    logic [NUM_PHASES-1:0]   w_grn_d;

    // Interval counter; reloads with the next state's duration on every expiry
    interval_timer #(
        .TIMER_W   (TIMER_W),
        .RESET_VAL (c_base_ld)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_expired),
        .load_val (w_load_val),
        .tick     (tick),
        .expired  (w_expired)
    );

`ifdef TLC_SKIP_IDLE_EN
    // Next approach with demand, scanning forward; approach 0 always qualifies
    always_comb begin
        w_adv_phase = '0;
        for (int j = NUM_PHASES - 1; j >= 1; j--) begin
            if (sensor[(int'(r_phase) + j) % NUM_PHASES] ||
                ((int'(r_phase) + j) % NUM_PHASES == 0)) begin
                w_adv_phase = c_ph_w'((int'(r_phase) + j) % NUM_PHASES);
            end
        end
    end
`else
    // Strict round-robin advance
    always_comb begin
        w_adv_phase = (r_phase == c_ph_w'(NUM_PHASES - 1)) ? '0 : r_phase + c_ph_w'(1);
    end
`endif

    // Transition target taken when the current interval expires
    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase;
        case (r_state)
            GREEN_BASE: w_next_state = sensor[r_phase] ? GREEN_EXT : YELLOW;
            GREEN_EXT:  w_next_state = YELLOW;
            YELLOW:     w_next_state = ALL_RED;
            ALL_RED: begin
                if (r_walk_pending) begin
                    w_next_state = WALK;
                end else begin
                    w_next_state = GREEN_BASE;
                    w_next_phase = w_adv_phase;
                end
            end
            WALK: begin
                w_next_state = GREEN_BASE;
                w_next_phase = w_adv_phase;
            end
            default: begin
                w_next_state = GREEN_BASE;
                w_next_phase = '0;
            end
        endcase
        w_nx_state = w_expired ? w_next_state : r_state;
        w_nx_phase = w_expired ? w_next_phase : r_phase;
    end

    // Duration of the state being entered, minus one
    always_comb begin
        case (w_next_state)
            GREEN_EXT: w_load_val = c_ext_ld;
            YELLOW:    w_load_val = c_yel_ld;
            ALL_RED:   w_load_val = c_clr_ld;
            WALK:      w_load_val = c_walk_ld;
            default:   w_load_val = c_base_ld;
        endcase
    end

    // Lamp pattern for the state/phase held after this clock edge
    always_comb begin
        w_lamp  = '0;
        w_red_d = '0;
        w_yel_d = '0;
        w_grn_d = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            w_lamp     = lamp_code(w_nx_state, (c_ph_w'(i) == w_nx_phase));
            w_red_d[i] = w_lamp[c_lamp_red];
            w_yel_d[i] = w_lamp[c_lamp_yel];
            w_grn_d[i] = w_lamp[c_lamp_grn];
        end
    end

    // State, phase, pedestrian latch and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= GREEN_BASE;
            r_phase        <= '0;
            r_walk_pending <= 1'b0;
            r_red          <= ~c_rst_grn;
            r_yel          <= '0;
            r_grn          <= c_rst_grn;
            r_walk         <= 1'b0;
            r_step         <= 1'b0;
        end else begin
            r_state <= w_nx_state;
            r_phase <= w_nx_phase;
            r_red   <= w_red_d;
            r_yel   <= w_yel_d;
            r_grn   <= w_grn_d;
            r_walk  <= (w_nx_state == WALK);
            r_step  <= w_expired;
            // A request arriving in the WALK entry cycle is served by this walk
            if (w_expired && (w_next_state == WALK)) begin
                r_walk_pending <= 1'b0;
            end else if (walk_req) begin
                r_walk_pending <= 1'b1;
            end
        end
    end

    assign red   = r_red;
    assign yel   = r_yel;
    assign grn   = r_grn;
    assign walk  = r_walk;
    assign phase = r_phase;
    assign state = r_state;
    assign step  = r_step;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Self-checking bench for traffic_phase_ctrl. A tick-counting
//               reference model predicts each state change; a monitor pops
//               predictions on every step pulse and checks lamps, state,
//               phase and interval lengths every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    localparam int NP = 3;
    localparam int PW = $clog2(NP);
    localparam int TW = 8;
    localparam int BT = 10;
    localparam int ET = 5;
    localparam int YT = 3;
    localparam int CT = 1;
    localparam int WT = 6;

    logic           clock    = 1'b0;
    logic           reset    = 1'b1;
    logic           tick     = 1'b0;
    logic           walk_req = 1'b0;
    logic [NP-1:0]  sensor   = '0;
    logic [NP-1:0]  red, yel, grn;
    logic           walk;
    logic [PW-1:0]  phase;
    logic [2:0]     state;
    logic           step;

    always #5 clock = ~clock;

    traffic_phase_ctrl #(
        .NUM_PHASES (NP),
        .TIMER_W    (TW),
        .BASE_TICKS (BT),
        .EXT_TICKS  (ET),
        .YEL_TICKS  (YT),
        .CLR_TICKS  (CT),
        .WALK_TICKS (WT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .sensor   (sensor),
        .walk_req (walk_req),
        .red      (red),
        .yel      (yel),
        .grn      (grn),
        .walk     (walk),
        .phase    (phase),
        .state    (state),
        .step     (step)
    );

    typedef struct {
        state_t st;
        int     ph;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    int     errors = 0;
    int     checks = 0;

    // Reference model: current interval and how many ticks it has consumed
    state_t m_st    = GREEN_BASE;
    int     m_ph    = 0;
    int     m_ticks = 0;
    int     m_seg   = 0;
    bit     m_pend  = 1'b0;

    function automatic int dur(input state_t s);
        case (s)
            GREEN_BASE: return BT;
            GREEN_EXT:  return ET;
            YELLOW:     return YT;
            ALL_RED:    return CT;
            default:    return WT;
        endcase
    endfunction

    function automatic int advance(input int p, input logic [NP-1:0] s);
`ifdef TLC_SKIP_IDLE_EN
        for (int j = 1; j < NP; j++) begin
            int k;
            k = (p + j) % NP;
            if (k == 0 || s[k]) return k;
        end
        return 0;
`else
        return (s == s) ? (p + 1) % NP : 0;
`endif
    endfunction

    // One clock of stimulus; the model consumes exactly what the DUT will sample
    task automatic drive(input bit r, input bit t, input logic [NP-1:0] s, input bit w);
        state_t ns;
        int     np;
        bit     go_walk;
        @(negedge clock);
        reset    = r;
        tick     = t;
        sensor   = s;
        walk_req = w;
        if (r) begin
            m_st = GREEN_BASE; m_ph = 0; m_ticks = 0; m_seg = 0; m_pend = 1'b0;
            q.delete();
            return;
        end
        m_seg++;
        go_walk = 1'b0;
        if (t) begin
            m_ticks++;
            if (m_ticks == dur(m_st)) begin
                np = m_ph;
                case (m_st)
                    GREEN_BASE: ns = s[m_ph] ? GREEN_EXT : YELLOW;
                    GREEN_EXT:  ns = YELLOW;
                    YELLOW:     ns = ALL_RED;
                    ALL_RED: begin
                        if (m_pend) ns = WALK;
                        else begin ns = GREEN_BASE; np = advance(m_ph, s); end
                    end
                    default: begin ns = GREEN_BASE; np = advance(m_ph, s); end
                endcase
                go_walk = (ns == WALK);
                m_st    = ns;
                m_ph    = np;
                m_ticks = 0;
                q.push_back('{ns, np, m_seg});
                m_seg   = 0;
            end
        end
        if (go_walk) m_pend = 1'b0;
        else if (w)  m_pend = 1'b1;
    endtask

    // Monitor: expected outputs follow the last predicted transition
    state_t c_st = GREEN_BASE;
    int     c_ph = 0;
    int     cnt  = 0;

    always @(posedge clock) begin
        exp_t          e;
        bit            exp_step;
        logic [NP-1:0] er, ey, eg;
        #1;
        exp_step = 1'b0;
        if (reset) begin
            c_st = GREEN_BASE;
            c_ph = 0;
            cnt  = 0;
        end else begin
            cnt++;
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_step = 1'b1;
                checks++;
                if (e.cyc != cnt) begin
                    errors++;
                    $display("FAIL interval_len t=%0t: got %0d cycles, expected %0d (entering state %0d)",
                             $time, cnt, e.cyc, e.st);
                end
                c_st = e.st;
                c_ph = e.ph;
                cnt  = 0;
            end
        end
        checks++;
        if (step !== exp_step) begin
            errors++;
            $display("FAIL step t=%0t: got %b, expected %b", $time, step, exp_step);
        end
        for (int i = 0; i < NP; i++) begin
            eg[i] = (i == c_ph) && (c_st == GREEN_BASE || c_st == GREEN_EXT);
            ey[i] = (i == c_ph) && (c_st == YELLOW);
            er[i] = !(eg[i] || ey[i]);
        end
        checks++;
        if (state !== c_st || phase !== PW'(c_ph) || red !== er || yel !== ey ||
            grn !== eg || walk !== (c_st == WALK)) begin
            errors++;
            $display("FAIL outputs t=%0t: got st=%0d ph=%0d r=%b y=%b g=%b w=%b, expected st=%0d ph=%0d r=%b y=%b g=%b w=%b",
                     $time, state, phase, red, yel, grn, walk,
                     c_st, c_ph, er, ey, eg, (c_st == WALK));
        end
    end

    initial begin
        logic [NP-1:0] rs;
        // Reset, then free-running tick with no demand
        drive(1, 0, '0, 0);
        drive(1, 1, '1, 1);
        for (int n = 0; n < 45; n++) drive(0, 1, '0, 0);
        // Demand everywhere, then dropped part-way so extensions must complete
        for (int n = 0; n < 20; n++) drive(0, 1, '1, 0);
        for (int n = 0; n < 25; n++) drive(0, 1, '0, 0);
        // Pedestrian pulse during a green, then another during the walk
        drive(1, 1, '0, 0);
        for (int n = 0; n < 3; n++) drive(0, 1, '0, 0);
        drive(0, 1, '0, 1);
        for (int n = 0; n < 200 && m_st != WALK; n++) drive(0, 1, '0, 0);
        drive(0, 1, '0, 0);
        drive(0, 1, '0, 1);
        for (int n = 0; n < 60; n++) drive(0, 1, '0, 0);
        // Skip-idle pattern: only approach 2 has demand
        for (int n = 0; n < 80; n++) drive(0, 1, 3'b100, 0);
        // Reset during yellow of phase 1 with a pending walk request
        drive(0, 1, '0, 1);
        for (int n = 0; n < 300 && !(m_st == YELLOW && m_ph == 1); n++) drive(0, 1, '0, 0);
        drive(0, 1, '0, 0);
        drive(1, 1, '1, 1);
        for (int n = 0; n < 40; n++) drive(0, 1, '0, 0);
        // Tick every fourth cycle stretches every interval
        for (int n = 0; n < 200; n++) drive(0, (n % 4) == 3, 3'b001, 0);
        // Randomised traffic
        rs = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) rs = NP'($urandom);
            drive(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), rs,
                  ($urandom_range(0, 19) == 0));
        end
        drive(0, 0, '0, 0);
        drive(0, 0, '0, 0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d predicted transitions left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
